// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Round-robin arbiter that shares one fixed-latency, fully pipelined
//   multiplier among N_REQ requesters. Each requester has at most one product
//   in flight. A tag pipeline follows every issue so that the product can be
//   returned to its owner as a one-hot response pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req        per-requester request, held until granted
//   op_a/op_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant (combinational from req and registered state)
//   mul_a/b    registered operands to the multiplier
//   mul_start  registered single-cycle issue strobe
//   mul_p      multiplier product, valid MUL_LAT cycles after mul_start
//   rsp_valid  registered one-hot response pulse
//   rsp_data   registered product for the pulsed requester
//   busy       high while any product is in flight
module mult_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic                   mul_start,
    input  logic [2*WIDTH-1:0]     mul_p,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    // Candidate index base+k, wrapped mod N_REQ (k < N_REQ).
    function automatic idx_t wrap_add(input idx_t base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return idx_t'(s);
    endfunction

    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] elig;
    idx_t             rr_ptr_q, rr_ptr_d;
    idx_t             gnt_idx;
    idx_t             cand;
    logic             gnt_any;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Tag pipeline: stage k is visible k+1 cycles after the grant cycle, so
    // the tail (stage MUL_LAT) lines up with the cycle mul_p is valid.
    logic             tag_vld_q [MUL_LAT+1];
    idx_t             tag_q     [MUL_LAT+1];
    logic             rsp_fire;
    idx_t             rsp_tag;
    logic [N_REQ-1:0] rsp_onehot;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        elig    = req & ~pending_q;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any && !reset) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a = op_a[gnt_idx*WIDTH +: WIDTH];
        sel_b = op_b[gnt_idx*WIDTH +: WIDTH];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == idx_t'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        rsp_fire   = tag_vld_q[MUL_LAT];
        rsp_tag    = tag_q[MUL_LAT];
        rsp_onehot = '0;
        if (rsp_fire) begin
            rsp_onehot[rsp_tag] = 1'b1;
        end
    end

    // A requester cannot be granted while pending, so the clear and the set
    // never target the same bit in one cycle.
    always_comb begin
        pending_d = pending_q & ~rsp_onehot;
        if (gnt_any) begin
            pending_d[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            pending_q <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int unsigned k = 0; k <= MUL_LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_q[k]     <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            mul_start <= gnt_any;
            if (gnt_any) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
            end
            tag_vld_q[0] <= gnt_any;
            tag_q[0]     <= gnt_idx;
            for (int unsigned k = 1; k <= MUL_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_q[k]     <= tag_q[k-1];
            end
            rsp_valid <= rsp_onehot;
            if (rsp_fire) begin
                rsp_data <= mul_p;
            end
        end
    end

    assign busy = |pending_q;

endmodule
